// File: rtl/multi_edge_counter_if.sv
// Read port of multi_edge_counter: request (sel/src) and registered response.
interface multi_edge_counter_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SELW  = 2
);
  logic             rd_en;
  logic [SELW-1:0]  rd_sel;
  logic             rd_src;
  logic             rd_valid;
  logic [WIDTH-1:0] rd_data;
  logic             rd_ovf;
  logic             rd_err;

  modport master (
    output rd_en, rd_sel, rd_src,
    input  rd_valid, rd_data, rd_ovf, rd_err
  );

  modport slave (
    input  rd_en, rd_sel, rd_src,
    output rd_valid, rd_data, rd_ovf, rd_err
  );
endinterface

// File: rtl/multi_edge_counter.sv
// Multi-channel edge counter: synchronise, edge-detect and count NUM_CH inputs,
// with snapshot/clear, sticky overflow and a registered read port.
module multi_edge_counter #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_MODE   = 0,
  parameter int unsigned SATURATE    = 0,
  parameter int unsigned SELW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_CH-1:0]   sig_in,
  input  logic [NUM_CH-1:0]   ch_en,
  input  logic                clear,
  input  logic                snap,
  multi_edge_counter_if.slave rd
);

  localparam int unsigned     WARMW   = $clog2(SYNC_STAGES + 2);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
  logic [NUM_CH-1:0] prev_q;
  logic [NUM_CH-1:0] s;
  logic [NUM_CH-1:0] rise;
  logic [NUM_CH-1:0] fall;
  logic [NUM_CH-1:0] ev;
  logic [NUM_CH-1:0] inc;
  logic [WARMW-1:0]  warm_q;
  logic              warm;

  logic [WIDTH-1:0]  cnt_q        [NUM_CH];
  logic [WIDTH-1:0]  cnt_d        [NUM_CH];
  logic [WIDTH-1:0]  shadow_cnt_q [NUM_CH];
  logic [NUM_CH-1:0] ovf_q;
  logic [NUM_CH-1:0] ovf_d;
  logic [NUM_CH-1:0] shadow_ovf_q;

  logic [WIDTH-1:0]  rd_data_d;
  logic              rd_ovf_d;
  logic              rd_err_d;

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~prev_q;
  assign fall = ~s & prev_q;
  assign warm = (warm_q != '0);
  assign inc  = ev & ch_en & {NUM_CH{~warm}};

  // Edge selection
  always_comb begin
    ev = rise;
    if (EDGE_MODE == 1)      ev = fall;
    else if (EDGE_MODE == 2) ev = rise | fall;
  end

  // Synchroniser, prev flop and warm-up countdown
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < SYNC_STAGES; j++) sync_q[j] <= '0;
      prev_q <= '0;
      warm_q <= WARMW'(SYNC_STAGES + 1);
    end else begin
      sync_q[0] <= sig_in;
      for (int j = 1; j < SYNC_STAGES; j++) sync_q[j] <= sync_q[j-1];
      prev_q <= s;
      if (warm) warm_q <= warm_q - WARMW'(1);
    end
  end

  // Counter next-state; clear wins over a same-cycle increment
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clear) begin
      for (int i = 0; i < NUM_CH; i++) cnt_d[i] = '0;
      ovf_d = '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (inc[i]) begin
          if (cnt_q[i] == CNT_MAX) begin
            ovf_d[i] = 1'b1;
            cnt_d[i] = (SATURATE != 0) ? CNT_MAX : '0;
          end else begin
            cnt_d[i] = cnt_q[i] + WIDTH'(1);
          end
        end
      end
    end
  end

  // Read mux over pre-update live or shadow values
  always_comb begin
    rd_data_d = '0;
    rd_ovf_d  = 1'b0;
    rd_err_d  = (32'(rd.rd_sel) >= NUM_CH);
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd.rd_sel == SELW'(i)) begin
        rd_data_d = rd.rd_src ? cnt_q[i] : shadow_cnt_q[i];
        rd_ovf_d  = rd.rd_src ? ovf_q[i] : shadow_ovf_q[i];
      end
    end
  end

  // Live counters, shadow copy and read response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]        <= '0;
        shadow_cnt_q[i] <= '0;
      end
      ovf_q        <= '0;
      shadow_ovf_q <= '0;
      rd.rd_valid  <= 1'b0;
      rd.rd_data   <= '0;
      rd.rd_ovf    <= 1'b0;
      rd.rd_err    <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      if (snap) begin
        shadow_cnt_q <= cnt_q;
        shadow_ovf_q <= ovf_q;
      end
      rd.rd_valid <= rd.rd_en;
      if (rd.rd_en) begin
        rd.rd_data <= rd_data_d;
        rd.rd_ovf  <= rd_ovf_d;
        rd.rd_err  <= rd_err_d;
      end
    end
  end

endmodule

// File: tb/tb_multi_edge_counter.sv
// Directed bench for multi_edge_counter: main 4-channel instance plus
// single-channel variants for overflow policy and edge modes.
module tb_multi_edge_counter;

  logic       clk;
  logic       rst_n;
  logic [3:0] sig_a;
  logic [3:0] ch_en;
  logic       clear;
  logic       snap;
  logic       sig_w;
  logic       sig_e;

  int n_chk;
  int n_err;

  logic        r_valid [5];
  logic [63:0] r_data  [5];
  logic        r_ovf   [5];
  logic        r_err   [5];

  multi_edge_counter_if #(.WIDTH(32), .SELW(3)) rif_a  ();
  multi_edge_counter_if #(.WIDTH(4),  .SELW(1)) rif_w0 ();
  multi_edge_counter_if #(.WIDTH(4),  .SELW(1)) rif_w1 ();
  multi_edge_counter_if #(.WIDTH(32), .SELW(1)) rif_b  ();
  multi_edge_counter_if #(.WIDTH(32), .SELW(1)) rif_f  ();

  multi_edge_counter #(.NUM_CH(4), .WIDTH(32), .EDGE_MODE(0), .SATURATE(0), .SELW(3)) u_dut (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_a), .ch_en(ch_en),
    .clear(clear), .snap(snap), .rd(rif_a));

  multi_edge_counter #(.NUM_CH(1), .WIDTH(4), .EDGE_MODE(0), .SATURATE(0)) u_w0 (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_w), .ch_en(1'b1),
    .clear(clear), .snap(snap), .rd(rif_w0));

  multi_edge_counter #(.NUM_CH(1), .WIDTH(4), .EDGE_MODE(0), .SATURATE(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_w), .ch_en(1'b1),
    .clear(clear), .snap(snap), .rd(rif_w1));

  multi_edge_counter #(.NUM_CH(1), .WIDTH(32), .EDGE_MODE(2)) u_b (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_e), .ch_en(1'b1),
    .clear(clear), .snap(snap), .rd(rif_b));

  multi_edge_counter #(.NUM_CH(1), .WIDTH(32), .EDGE_MODE(1)) u_f (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_e), .ch_en(1'b1),
    .clear(clear), .snap(snap), .rd(rif_f));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges, landing 1 time unit after the last one
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_sig(input int which, input int ch, input logic v);
    case (which)
      0:       sig_a[ch] = v;
      1:       sig_w     = v;
      default: sig_e     = v;
    endcase
  endtask

  // n pulses at clk/4 (2 cycles high, 2 low)
  task automatic pulses(input int which, input int ch, input int n);
    repeat (n) begin
      set_sig(which, ch, 1'b1);
      cyc(2);
      set_sig(which, ch, 1'b0);
      cyc(2);
    end
  endtask

  task automatic set_rd(input logic en, input logic [2:0] sel, input logic src);
    rif_a.rd_en  = en; rif_a.rd_sel  = sel;  rif_a.rd_src  = src;
    rif_w0.rd_en = en; rif_w0.rd_sel = 1'b0; rif_w0.rd_src = src;
    rif_w1.rd_en = en; rif_w1.rd_sel = 1'b0; rif_w1.rd_src = src;
    rif_b.rd_en  = en; rif_b.rd_sel  = 1'b0; rif_b.rd_src  = src;
    rif_f.rd_en  = en; rif_f.rd_sel  = 1'b0; rif_f.rd_src  = src;
  endtask

  task automatic capture();
    r_valid[0] = rif_a.rd_valid;  r_data[0] = 64'(rif_a.rd_data);
    r_ovf[0]   = rif_a.rd_ovf;    r_err[0]  = rif_a.rd_err;
    r_valid[1] = rif_w0.rd_valid; r_data[1] = 64'(rif_w0.rd_data);
    r_ovf[1]   = rif_w0.rd_ovf;   r_err[1]  = rif_w0.rd_err;
    r_valid[2] = rif_w1.rd_valid; r_data[2] = 64'(rif_w1.rd_data);
    r_ovf[2]   = rif_w1.rd_ovf;   r_err[2]  = rif_w1.rd_err;
    r_valid[3] = rif_b.rd_valid;  r_data[3] = 64'(rif_b.rd_data);
    r_ovf[3]   = rif_b.rd_ovf;    r_err[3]  = rif_b.rd_err;
    r_valid[4] = rif_f.rd_valid;  r_data[4] = 64'(rif_f.rd_data);
    r_ovf[4]   = rif_f.rd_ovf;    r_err[4]  = rif_f.rd_err;
  endtask

  // Single read on all instances; results land in r_*
  task automatic do_read(input logic [2:0] sel, input logic src);
    set_rd(1'b1, sel, src);
    cyc(1);
    set_rd(1'b0, 3'd0, 1'b0);
    capture();
  endtask

  task automatic pulse_ctl(input logic do_clear, input logic do_snap);
    clear = do_clear;
    snap  = do_snap;
    cyc(1);
    clear = 1'b0;
    snap  = 1'b0;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    sig_a = 4'b0001;
    sig_w = 1'b0;
    sig_e = 1'b0;
    ch_en = 4'hF;
    clear = 1'b0;
    snap  = 1'b0;
    set_rd(1'b0, 3'd0, 1'b0);

    // Reset state
    cyc(2);
    chk("rst_valid", 64'(rif_a.rd_valid), 64'd0);
    chk("rst_data",  64'(rif_a.rd_data),  64'd0);
    chk("rst_err",   64'(rif_a.rd_err),   64'd0);

    // Level held high through reset release must not count
    rst_n = 1'b1;
    cyc(8);
    do_read(3'd0, 1'b1);
    chk("warm_valid", 64'(r_valid[0]), 64'd1);
    chk("warm_cnt",   r_data[0],       64'd0);

    // Latency: sig sampled at edge k, counted at edge k+2; back-to-back live reads
    sig_a[0] = 1'b0;
    cyc(4);
    sig_a[0] = 1'b1;
    cyc(1);
    set_rd(1'b1, 3'd0, 1'b1);
    cyc(1);
    chk("lat_k1", 64'(rif_a.rd_data), 64'd0);
    cyc(1);
    chk("lat_k2", 64'(rif_a.rd_data), 64'd0);
    chk("lat_k2_valid", 64'(rif_a.rd_valid), 64'd1);
    cyc(1);
    chk("lat_k3", 64'(rif_a.rd_data), 64'd1);
    set_rd(1'b0, 3'd0, 1'b0);
    cyc(1);
    chk("lat_idle_valid", 64'(rif_a.rd_valid), 64'd0);
    sig_a[0] = 1'b0;
    cyc(4);

    // Basic counts
    pulse_ctl(1'b1, 1'b0);
    pulses(0, 0, 10);
    pulses(0, 1, 3);
    cyc(4);
    for (int c = 0; c < 4; c++) begin
      logic [63:0] exp_c;
      exp_c = (c == 0) ? 64'd10 : (c == 1) ? 64'd3 : 64'd0;
      do_read(3'(c), 1'b1);
      chk($sformatf("basic_cnt%0d", c), r_data[0], exp_c);
      chk($sformatf("basic_ovf%0d", c), 64'(r_ovf[0]), 64'd0);
    end

    // Enable gating: 3 pulses disabled, 2 enabled
    pulse_ctl(1'b1, 1'b0);
    ch_en[0] = 1'b0;
    pulses(0, 0, 3);
    ch_en[0] = 1'b1;
    cyc(4);
    pulses(0, 0, 2);
    cyc(4);
    do_read(3'd0, 1'b1);
    chk("en_cnt", r_data[0], 64'd2);

    // Atomic snap + clear at count 7
    pulse_ctl(1'b1, 1'b0);
    pulses(0, 0, 7);
    cyc(4);
    pulse_ctl(1'b1, 1'b1);
    do_read(3'd0, 1'b0);
    chk("snapclr_shadow", r_data[0], 64'd7);
    do_read(3'd0, 1'b1);
    chk("snapclr_live", r_data[0], 64'd0);

    // Clear on the same edge as an increment
    sig_a[0] = 1'b1;
    cyc(2);
    pulse_ctl(1'b1, 1'b0);
    sig_a[0] = 1'b0;
    cyc(5);
    do_read(3'd0, 1'b1);
    chk("clr_edge_live", r_data[0], 64'd0);

    // Snap on the edge taking 4 to 5
    pulses(0, 0, 4);
    cyc(2);
    sig_a[0] = 1'b1;
    cyc(2);
    pulse_ctl(1'b0, 1'b1);
    sig_a[0] = 1'b0;
    cyc(5);
    do_read(3'd0, 1'b0);
    chk("snap_edge_shadow", r_data[0], 64'd4);
    do_read(3'd0, 1'b1);
    chk("snap_edge_live", r_data[0], 64'd5);

    // Out-of-range and last valid selector
    do_read(3'd5, 1'b1);
    chk("err_valid", 64'(r_valid[0]), 64'd1);
    chk("err_flag",  64'(r_err[0]),   64'd1);
    chk("err_data",  r_data[0],       64'd0);
    chk("err_ovf",   64'(r_ovf[0]),   64'd0);
    do_read(3'd3, 1'b1);
    chk("sel3_err",  64'(r_err[0]),   64'd0);

    // Overflow policy on 4-bit counters: 15 edges then 2 more
    pulses(1, 0, 15);
    cyc(4);
    do_read(3'd0, 1'b1);
    chk("wrap15_cnt", r_data[1], 64'd15);
    chk("wrap15_ovf", 64'(r_ovf[1]), 64'd0);
    chk("sat15_cnt",  r_data[2], 64'd15);
    chk("sat15_ovf",  64'(r_ovf[2]), 64'd0);
    pulses(1, 0, 2);
    cyc(4);
    do_read(3'd0, 1'b1);
    chk("wrap17_cnt", r_data[1], 64'd1);
    chk("wrap17_ovf", 64'(r_ovf[1]), 64'd1);
    chk("sat17_cnt",  r_data[2], 64'd15);
    chk("sat17_ovf",  64'(r_ovf[2]), 64'd1);

    // Edge modes: 5 full pulses
    pulses(2, 0, 5);
    cyc(4);
    do_read(3'd0, 1'b1);
    chk("both_cnt", r_data[3], 64'd10);
    chk("fall_cnt", r_data[4], 64'd5);

    // Reset during a read in flight
    do_read(3'd0, 1'b1);
    chk("pre_rst_data", r_data[0], 64'd5);
    set_rd(1'b1, 3'd0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(rif_a.rd_valid), 64'd0);
    chk("async_rst_data",  64'(rif_a.rd_data),  64'd0);
    @(posedge clk);
    #1;
    chk("rst_inflight_valid", 64'(rif_a.rd_valid), 64'd0);
    set_rd(1'b0, 3'd0, 1'b0);
    cyc(2);
    rst_n = 1'b1;
    cyc(8);
    do_read(3'd0, 1'b1);
    chk("post_rst_live", r_data[0], 64'd0);
    do_read(3'd0, 1'b0);
    chk("post_rst_shadow", r_data[0], 64'd0);
    do_read(3'd0, 1'b1);
    chk("post_rst_wovf", 64'(r_ovf[1]), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
